lif_scheduler: RTL and testbench
================================

LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of time-multiplexed neurons (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, bit width of membrane state, current and threshold.
REQ-003 SHALL have parameter DEFAULT_THRESH, default 230, reset value of every threshold register.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request one update frame over all neurons.
REQ-007 SHALL have port current  input  N_NEURONS*WIDTH  per-neuron input currents; neuron i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port cfg_we  input  1  threshold write strobe.
REQ-009 SHALL have port cfg_addr  input  clog2(N_NEURONS)  threshold write index.
REQ-010 SHALL have port cfg_data  input  WIDTH  threshold write value.
REQ-011 SHALL have port rd_addr  input  clog2(N_NEURONS)  membrane state readback index.
REQ-012 SHALL have port rd_state  output  WIDTH  registered membrane state of neuron rd_addr.
REQ-013 SHALL have port spikes  output  N_NEURONS  registered per-neuron spike flags of the last frame.
REQ-014 SHALL have port busy  output  1  high while a frame is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, UPDATE, DONE.
REQ-017 SHALL, in IDLE with start=1 at edge E0: latch all of current into a snapshot register, clear idx to 0, enter UPDATE, set busy=1.
REQ-018 SHALL, in UPDATE, process neuron idx at each edge E1..EN using snapshot current[idx], state[idx] and thresh[idx], then increment idx.
REQ-019 SHALL compute spike = (state >= thresh); next state = 0 if spike, else min(current + (state>>1) + (state>>2) + (state>>3), 2^WIDTH-1), summed at WIDTH+2 bits and saturated.
REQ-020 SHALL write spikes[idx] with the computed spike at the same edge as state[idx].
REQ-021 SHALL, at edge EN (idx = N_NEURONS-1), enter DONE and assert done=1 for the following cycle only.
REQ-022 SHALL, from DONE, enter IDLE at edge E(N+1), clearing done and busy; busy is therefore high exactly N_NEURONS+1 cycles.
REQ-023 SHALL ignore start while busy=1, including in DONE; no queuing.
REQ-024 SHALL ignore changes on current after E0 until the next accepted start.
REQ-025 SHALL apply cfg_we writes thresh[cfg_addr] <= cfg_data only in IDLE; writes while busy=1 are dropped.
REQ-026 SHALL give priority to start when cfg_we and start coincide in IDLE: the write completes at the same edge but is not used until the next frame; the frame uses pre-edge thresholds.
REQ-027 SHALL treat thresh=0 as always spike: that neuron spikes every frame and its state stays 0.
REQ-028 SHALL register rd_state <= state[rd_addr] every cycle; readback latency is 1 cycle.
REQ-029 SHALL hold spikes stable outside UPDATE.

Reset
REQ-030 SHALL, when rst_n=0 at an edge (any state, mid-frame included), set FSM=IDLE, idx=0, all states=0, all thresh=DEFAULT_THRESH, snapshot=0, spikes=0, busy=0, done=0, rd_state=0.
REQ-031 SHALL ignore start and cfg_we during the reset cycle.

Structure
REQ-032 SHALL place FSM state encoding and the DEFAULT_THRESH / WIDTH defaults in a shared package, lif_pkg.
REQ-033 SHALL implement the update rule (REQ-019) as a combinational sub-module lif_core, instantiated once and shared across all neurons.

Verification
REQ-034 SHALL cover saturation: neuron 0, current 100 for four frames, default thresh -> state 100, 187, 255 (saturated) with spike 0; fourth frame spike 1, state 0.
REQ-035 SHALL cover timing: start at E0 -> busy=1 after E0, done=1 exactly in the cycle after E4 (N=4), busy=0 after E5.
REQ-036 SHALL cover start dropping: start held high through a frame -> a new frame begins only at the first edge in IDLE; no extra done pulse.
REQ-037 SHALL cover config: write thresh[2]=50 in IDLE, frames with current 60 -> neuron 2 state 60 then spike 1 / state 0; a cfg write during busy leaves thresh unchanged.
REQ-038 SHALL cover thresh=0: neuron 1 spikes every frame and its state stays 0 under any current.
REQ-039 SHALL cover reset mid-frame: rst_n=0 at E2 -> IDLE, states 0, spikes 0, thresh 230, no done pulse.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM encoding and parameter defaults.
package lif_pkg;

  localparam int LIF_WIDTH          = 8;
  localparam int LIF_DEFAULT_THRESH = 230;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } lif_state_e;

endpackage : lif_pkg

// File: rtl/lif_scheduler_if.sv
// Operand/result bundle between the frame scheduler and the shared LIF update core.
interface lif_scheduler_if #(
  parameter int WIDTH = lif_pkg::LIF_WIDTH
);

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] thresh;
  logic [WIDTH-1:0] next_state;
  logic             spike;

  modport master (output cur, state, thresh, input  next_state, spike);
  modport slave  (input  cur, state, thresh, output next_state, spike);

endinterface : lif_scheduler_if

// File: rtl/lif_core.sv
// Combinational leaky integrate-and-fire update for one neuron; shared by all neurons.
module lif_core
  import lif_pkg::*;
#(
  parameter int WIDTH = LIF_WIDTH
) (
  lif_scheduler_if.slave core_if
);

  // Two guard bits hold the worst-case sum of current plus the three leak taps.
  logic [WIDTH+1:0] sum;

  always_comb begin
    sum = {2'b00, core_if.cur}
        + {2'b00, core_if.state >> 1}
        + {2'b00, core_if.state >> 2}
        + {2'b00, core_if.state >> 3};
  end

  always_comb begin
    core_if.spike = (core_if.state >= core_if.thresh);
    if (core_if.spike) begin
      core_if.next_state = '0;
    end else if (|sum[WIDTH+1:WIDTH]) begin
      core_if.next_state = '1;
    end else begin
      core_if.next_state = sum[WIDTH-1:0];
    end
  end

endmodule : lif_core

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron array: one neuron updated per cycle through a shared core,
// with programmable thresholds, registered state readback and per-frame spike flags.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 4,
  parameter int WIDTH          = LIF_WIDTH,
  parameter int DEFAULT_THRESH = LIF_DEFAULT_THRESH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_NEURONS*WIDTH-1:0]    current,
  input  logic                          cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
  input  logic [WIDTH-1:0]              cfg_data,
  input  logic [$clog2(N_NEURONS)-1:0]  rd_addr,
  output logic [WIDTH-1:0]              rd_state,
  output logic [N_NEURONS-1:0]          spikes,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(N_NEURONS);

  lif_state_e           fsm_q,      fsm_d;
  logic [AW-1:0]        idx_q,      idx_d;
  logic [WIDTH-1:0]     state_q     [N_NEURONS];
  logic [WIDTH-1:0]     state_d     [N_NEURONS];
  logic [WIDTH-1:0]     thresh_q    [N_NEURONS];
  logic [WIDTH-1:0]     thresh_d    [N_NEURONS];
  logic [WIDTH-1:0]     thr_snap_q  [N_NEURONS];
  logic [WIDTH-1:0]     thr_snap_d  [N_NEURONS];
  logic [WIDTH-1:0]     cur_snap_q  [N_NEURONS];
  logic [WIDTH-1:0]     cur_snap_d  [N_NEURONS];
  logic [N_NEURONS-1:0] spikes_q,   spikes_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic [WIDTH-1:0]     rd_state_q, rd_state_d;

  logic cfg_in_range;
  logic rd_in_range;

  lif_scheduler_if #(.WIDTH(WIDTH)) core_if ();

  lif_core #(.WIDTH(WIDTH)) u_core (
    .core_if (core_if)
  );

  // Thresholds come from the copy taken at frame start, so a write that lands on the
  // accepting edge only affects the following frame.
  assign core_if.cur    = cur_snap_q[idx_q];
  assign core_if.state  = state_q[idx_q];
  assign core_if.thresh = thr_snap_q[idx_q];

  assign cfg_in_range = ({1'b0, cfg_addr} < (AW+1)'(N_NEURONS));
  assign rd_in_range  = ({1'b0, rd_addr}  < (AW+1)'(N_NEURONS));

  // NOTE: every _d gets its _q value first, so no path through this block leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    state_d    = state_q;
    thresh_d   = thresh_q;
    thr_snap_d = thr_snap_q;
    cur_snap_d = cur_snap_q;
    spikes_d   = spikes_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rd_state_d = rd_in_range ? state_q[rd_addr] : '0;

    unique case (fsm_q)
      IDLE: begin
        if (cfg_we && cfg_in_range) begin
          thresh_d[cfg_addr] = cfg_data;
        end
        if (start) begin
          fsm_d      = UPDATE;
          idx_d      = '0;
          busy_d     = 1'b1;
          thr_snap_d = thresh_q;
          for (int i = 0; i < N_NEURONS; i++) begin
            cur_snap_d[i] = current[i*WIDTH +: WIDTH];
          end
        end
      end
      UPDATE: begin
        state_d[idx_q]  = core_if.next_state;
        spikes_d[idx_q] = core_if.spike;
        if (idx_q == AW'(N_NEURONS-1)) begin
          fsm_d  = DONE;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        fsm_d  = IDLE;
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        fsm_d  = IDLE;
        done_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      idx_q      <= '0;
      spikes_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_state_q <= '0;
      // NOTE: the small register files are cleared explicitly because a reset frame
      // must start from zero membrane state and default thresholds.
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]    <= '0;
        thresh_q[i]   <= WIDTH'(DEFAULT_THRESH);
        thr_snap_q[i] <= WIDTH'(DEFAULT_THRESH);
        cur_snap_q[i] <= '0;
      end
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      thresh_q   <= thresh_d;
      thr_snap_q <= thr_snap_d;
      cur_snap_q <= cur_snap_d;
      spikes_q   <= spikes_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign rd_state = rd_state_q;
  assign spikes   = spikes_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : lif_scheduler

// File: tb/tb_lif_scheduler.sv
// Directed self-checking bench for lif_scheduler: frame timing, saturation, thresholds,
// start dropping, always-spike threshold and mid-frame reset.
module tb_lif_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N*W-1:0] current = '0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_addr = '0;
  logic [W-1:0]   cfg_data = '0;
  logic [1:0]     rd_addr = '0;
  logic [W-1:0]   rd_state;
  logic [N-1:0]   spikes;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;

  int       m_state [N];
  int       m_thr   [N];
  logic [N-1:0] m_spk;

  always #5 clk = ~clk;

  lif_scheduler #(.N_NEURONS(N), .WIDTH(W), .DEFAULT_THRESH(230)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .current  (current),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .rd_addr  (rd_addr),
    .rd_state (rd_state),
    .spikes   (spikes),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lif_next(input int c, input int s);
    int t;
    t = c + s / 2 + s / 4 + s / 8;
    return (t > 255) ? 255 : t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_thr[i]   = 230;
    end
    m_spk = '0;
  endtask

  // All tasks start and end right after a falling edge.
  task automatic cfg_write(input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av = a;
    dv = d;
    cfg_we   = 1'b1;
    cfg_addr = av[1:0];
    cfg_data = dv[7:0];
    @(negedge clk);
    cfg_we = 1'b0;
    m_thr[a] = d;
  endtask

  task automatic read_one(input int a, output int val);
    logic [31:0] av;
    av = a;
    rd_addr = av[1:0];
    @(negedge clk);
    val = int'(rd_state);
  endtask

  task automatic read_all(input string tag);
    int v;
    for (int i = 0; i < N; i++) begin
      read_one(i, v);
      check($sformatf("%s rd_state[%0d]", tag, i), v, m_state[i]);
    end
    check($sformatf("%s spikes held", tag), spikes, m_spk);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] cur, input bit hold,
                           input bit cfg_start, input bit cfg_busy, input int ca, input int cd);
    int snap [N];
    logic [31:0] av;
    logic [31:0] dv;
    av = ca;
    dv = cd;
    current = cur;
    start   = 1'b1;
    if (cfg_start) begin
      cfg_we   = 1'b1;
      cfg_addr = av[1:0];
      cfg_data = dv[7:0];
    end
    @(posedge clk);
    snap = m_thr;
    if (cfg_start) m_thr[ca] = cd;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!hold) start = 1'b0;
    current = ~cur;
    check({tag, " busy after E0"}, busy, 1);
    check({tag, " done after E0"}, done, 0);
    if (cfg_busy) begin
      cfg_we   = 1'b1;
      cfg_addr = av[1:0];
      cfg_data = dv[7:0];
    end
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      check($sformatf("%s busy after E%0d", tag, k), busy, 1);
      check($sformatf("%s done after E%0d", tag, k), done, 32'(k == N));
    end
    @(negedge clk);
    check({tag, " busy after E5"}, busy, 0);
    check({tag, " done after E5"}, done, 0);
    for (int i = 0; i < N; i++) begin
      m_spk[i]   = (m_state[i] >= snap[i]);
      m_state[i] = m_spk[i] ? 0 : lif_next(int'(cur[i*W +: W]), m_state[i]);
    end
    check({tag, " spikes"}, spikes, m_spk);
    if (!hold) read_all(tag);
  endtask

  task automatic frame_expect(input string tag, input logic [31:0] cur, input bit cfg_start,
                              input bit cfg_busy, input int ca, input int cd,
                              input int n, input int exp_state, input int exp_spk);
    int v;
    run_frame(tag, cur, 1'b0, cfg_start, cfg_busy, ca, cd);
    read_one(n, v);
    check($sformatf("%s neuron%0d state", tag, n), v, exp_state);
    check($sformatf("%s neuron%0d spike", tag, n), spikes[n], exp_spk);
  endtask

  initial begin
    int sat_state [4] = '{100, 187, 255, 0};
    int sat_spk   [4] = '{0, 0, 0, 1};

    model_reset();

    // Reset with start and cfg_we asserted: both must be ignored.
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 8'd3;
    current  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset spikes", spikes, 0);
    check("reset rd_state", rd_state, 0);
    start  = 1'b0;
    cfg_we = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("post-reset busy", busy, 0);
    read_all("reset");

    // Saturation on neuron 0 with the default threshold.
    for (int f = 0; f < 4; f++) begin
      frame_expect($sformatf("sat f%0d", f), 32'd100, 1'b0, 1'b0, 0, 0, 0,
                   sat_state[f], sat_spk[f]);
    end

    // Threshold config on neuron 2; a write while busy is dropped.
    cfg_write(2, 50);
    frame_expect("cfg A", 32'h003C_0000, 1'b0, 1'b0, 0, 0, 2, 60, 0);
    frame_expect("cfg B busy-write", 32'h003C_0000, 1'b0, 1'b1, 2, 255, 2, 0, 1);
    frame_expect("cfg C", 32'h003C_0000, 1'b0, 1'b0, 0, 0, 2, 60, 0);
    // Write coinciding with start: this frame still sees threshold 50.
    frame_expect("cfg D coincident", 32'h003C_0000, 1'b1, 1'b0, 2, 200, 2, 0, 1);
    frame_expect("cfg E", 32'h003C_0000, 1'b0, 1'b0, 0, 0, 2, 60, 0);
    frame_expect("cfg F", 32'h003C_0000, 1'b0, 1'b0, 0, 0, 2, 112, 0);

    // Start held high: the second frame begins on the first IDLE edge.
    run_frame("hold 1", 32'h0A0A_0A0A, 1'b1, 1'b0, 1'b0, 0, 0);
    run_frame("hold 2", 32'h0A0A_0A0A, 1'b0, 1'b0, 1'b0, 0, 0);

    // Threshold zero: neuron 1 spikes every frame and stays at 0.
    cfg_write(1, 0);
    frame_expect("thr0 a", 32'h0000_C800, 1'b0, 1'b0, 0, 0, 1, 0, 1);
    frame_expect("thr0 b", 32'h0000_2500, 1'b0, 1'b0, 0, 0, 1, 0, 1);
    frame_expect("thr0 c", 32'h0000_FF00, 1'b0, 1'b0, 0, 0, 1, 0, 1);

    // Reset asserted on E2 of a frame.
    current = 32'h5050_5050;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst spikes", spikes, 0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst no done %0d", k), done, 0);
      check($sformatf("midrst idle busy %0d", k), busy, 0);
    end
    read_all("midrst");
    // Neuron 1 threshold is back at 230, not 0.
    frame_expect("midrst thr a", 32'h0000_F000, 1'b0, 1'b0, 0, 0, 1, 240, 0);
    frame_expect("midrst thr b", 32'h0000_F000, 1'b0, 1'b0, 0, 0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_lif_scheduler
